apple_bus_master: RTL and testbench

- Host-side initiator for the Apple II slot bus; drives the other end of the peripheral-card protocol.
- Generates PHI1 from C7M and runs 6502-style bus cycles: A, nWE, slot-decoded nDEVSEL/nIOSEL/nIOSTRB, and D.
- A simple request/ack interface executes single or repeated-address (burst) accesses. Typical target: the card's auto-incrementing RAM data port.
- Used as the motherboard model in card-level benches and in the bench-top card tester.

---
 rtl/apple_bus_pkg.sv | 38 +++
 rtl/apple_bus_timing.sv | 63 ++++++
 rtl/apple_bus_master.sv | 144 ++++++++++++++
 tb/tb_apple_bus_master.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/apple_bus_pkg.sv
// Shared constants, FSM state type and slot address decode for the Apple II bus master.
package apple_bus_pkg;

  localparam int unsigned CYC_SHORT = 32'd7;
  localparam int unsigned CYC_LONG  = 32'd8;
  localparam int unsigned PHI1_HIGH = 32'd4;
  localparam logic [6:0]  CYC_COUNT_LAST = 7'd64;

  localparam logic [15:0] DEVSEL_BASE = 16'hC080;
  localparam logic [15:0] IOSEL_BASE  = 16'hC000;
  localparam logic [15:0] IOSTRB_BASE = 16'hC800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_BEAT = 2'd2
  } state_t;

  typedef struct packed {
    logic devsel;
    logic iosel;
    logic iostrb;
  } sel_t;

  // Active-high window hits; windows are disjoint for slots 1..7.
  function automatic sel_t decode(input logic [15:0] addr, input logic [2:0] slot);
    sel_t        hit;
    logic [15:0] dev_base;
    logic [15:0] io_base;
    dev_base   = DEVSEL_BASE + {9'd0, slot, 4'd0};
    io_base    = IOSEL_BASE + {5'd0, slot, 8'd0};
    hit.devsel = (addr[15:4] == dev_base[15:4]);
    hit.iosel  = (addr[15:8] == io_base[15:8]);
    hit.iostrb = (addr[15:11] == IOSTRB_BASE[15:11]);
    return hit;
  endfunction

endpackage

// File: rtl/apple_bus_timing.sv
// Free-running bus phase counter: 7 C7M clocks per cycle, 8 on every 65th when enabled.
module apple_bus_timing
  import apple_bus_pkg::*;
#(
  parameter int LONG_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] p,
  output logic       last,
  output logic       phi1
);

  localparam logic [2:0] P_LAST_SHORT = 3'(CYC_SHORT - 32'd1);
  localparam logic [2:0] P_LAST_LONG  = 3'(CYC_LONG - 32'd1);
  localparam logic [2:0] P_PHI1_END   = 3'(PHI1_HIGH);

  logic [2:0] p_r;
  logic [6:0] cyc_r;
  logic       phi1_r;
  logic       long_s;
  logic       last_s;
  logic [2:0] p_next_s;

  // Next-phase and end-of-cycle decode.
  always_comb begin
    long_s = (LONG_CYCLE != 32'sd0) && (cyc_r == CYC_COUNT_LAST);
    if (long_s) begin
      last_s = (p_r == P_LAST_LONG);
    end else begin
      last_s = (p_r == P_LAST_SHORT);
    end
    if (last_s) begin
      p_next_s = 3'd0;
    end else begin
      p_next_s = p_r + 3'd1;
    end
  end

  // Phase, cycle count and PHI1 registers; PHI1 is registered from the next phase so it lines up with P.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r    <= 3'd0;
      cyc_r  <= 7'd0;
      phi1_r <= 1'b1;
    end else begin
      p_r    <= p_next_s;
      phi1_r <= (p_next_s < P_PHI1_END);
      if (last_s) begin
        if (cyc_r == CYC_COUNT_LAST) begin
          cyc_r <= 7'd0;
        end else begin
          cyc_r <= cyc_r + 7'd1;
        end
      end
    end
  end

  assign p    = p_r;
  assign last = last_s;
  assign phi1 = phi1_r;

endmodule

// File: rtl/apple_bus_master.sv
// Apple II slot-bus initiator: request/ack front end running single or repeated-address bus cycles.
module apple_bus_master
  import apple_bus_pkg::*;
#(
  parameter int SLOT       = 5,
  parameter int LONG_CYCLE = 1
) (
  input  logic        C7M,
  input  logic        nRES,
  output logic        PHI1,
  output logic [15:0] A,
  output logic        nWE,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        nDEVSEL,
  output logic        nIOSEL,
  output logic        nIOSTRB,
  input  logic        req,
  input  logic [15:0] req_addr,
  input  logic        req_we,
  input  logic [7:0]  req_len,
  input  logic [7:0]  wr_data,
  output logic        busy,
  output logic        beat_valid,
  output logic [7:0]  beat_data,
  output logic        done
);

  localparam logic [2:0] SLOT_NUM = 3'(SLOT);
  // Selects and the write driver switch on the edge that enters PHI0.
  localparam logic [2:0] P_SEL = 3'(PHI1_HIGH - 32'd1);

  logic [2:0]  p_s;
  logic        last_s;
  sel_t        hit_s;

  state_t      state_r;
  logic [15:0] addr_r;
  logic        we_r;
  logic [7:0]  rem_r;
  logic [15:0] a_r;
  logic        nwe_r;
  logic [7:0]  dout_r;
  logic        doe_r;
  sel_t        nsel_r;
  logic        busy_r;
  logic        bv_r;
  logic [7:0]  bdata_r;
  logic        done_r;

  apple_bus_timing #(.LONG_CYCLE(LONG_CYCLE)) u_timing (
    .clk   (C7M),
    .rst_n (nRES),
    .p     (p_s),
    .last  (last_s),
    .phi1  (PHI1)
  );

  assign hit_s = decode(a_r, SLOT_NUM);

  // Transaction FSM and all registered bus/status outputs.
  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      state_r <= ST_IDLE;
      addr_r  <= 16'h0000;
      we_r    <= 1'b0;
      rem_r   <= 8'd0;
      a_r     <= 16'h0000;
      nwe_r   <= 1'b1;
      dout_r  <= 8'h00;
      doe_r   <= 1'b0;
      nsel_r  <= 3'b111;
      busy_r  <= 1'b0;
      bv_r    <= 1'b0;
      bdata_r <= 8'h00;
      done_r  <= 1'b0;
    end else begin
      bv_r   <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            addr_r  <= req_addr;
            we_r    <= req_we;
            rem_r   <= (req_len == 8'd0) ? 8'd1 : req_len;
            busy_r  <= 1'b1;
            state_r <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (last_s) begin
            a_r     <= addr_r;
            nwe_r   <= ~we_r;
            state_r <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          if (p_s == P_SEL) begin
            nsel_r <= ~hit_s;
            doe_r  <= we_r;
            if (we_r) begin
              dout_r <= wr_data;
            end
          end else if (last_s) begin
            nsel_r <= 3'b111;
            doe_r  <= 1'b0;
            bv_r   <= 1'b1;
            if (!we_r) begin
              bdata_r <= D_in;
            end
            if (rem_r == 8'd1) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              nwe_r   <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              rem_r <= rem_r - 8'd1;
              a_r   <= addr_r;
              nwe_r <= ~we_r;
            end
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign A          = a_r;
  assign nWE        = nwe_r;
  assign D_out      = dout_r;
  assign D_oe       = doe_r;
  assign nDEVSEL    = nsel_r.devsel;
  assign nIOSEL     = nsel_r.iosel;
  assign nIOSTRB    = nsel_r.iostrb;
  assign busy       = busy_r;
  assign beat_valid = bv_r;
  assign beat_data  = bdata_r;
  assign done       = done_r;

endmodule

// File: tb/tb_apple_bus_master.sv
// Directed bench for apple_bus_master (SLOT=5, LONG_CYCLE=1); samples every output on the falling edge.
module tb_apple_bus_master;

  logic        C7M;
  logic        nRES;
  logic        PHI1;
  logic [15:0] A;
  logic        nWE;
  logic [7:0]  D_out;
  logic        D_oe;
  logic [7:0]  D_in;
  logic        nDEVSEL;
  logic        nIOSEL;
  logic        nIOSTRB;
  logic        req;
  logic [15:0] req_addr;
  logic        req_we;
  logic [7:0]  req_len;
  logic [7:0]  wr_data;
  logic        busy;
  logic        beat_valid;
  logic [7:0]  beat_data;
  logic        done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  logic        last_phi1;
  logic        rise;
  logic [9:0]  phi_pat, nwe_pat, dev_pat, io_pat, strb_pat, oe_pat, done_pat, bv_pat;
  logic [15:0] a_p0, a_last;
  logic [7:0]  dout_last;

  apple_bus_master #(.SLOT(5), .LONG_CYCLE(1)) dut (
    .C7M        (C7M),
    .nRES       (nRES),
    .PHI1       (PHI1),
    .A          (A),
    .nWE        (nWE),
    .D_out      (D_out),
    .D_oe       (D_oe),
    .D_in       (D_in),
    .nDEVSEL    (nDEVSEL),
    .nIOSEL     (nIOSEL),
    .nIOSTRB    (nIOSTRB),
    .req        (req),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_len    (req_len),
    .wr_data    (wr_data),
    .busy       (busy),
    .beat_valid (beat_valid),
    .beat_data  (beat_data),
    .done       (done)
  );

  initial C7M = 1'b0;
  always #5 C7M = ~C7M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; rise marks the first sample of a bus cycle (P=0).
  task automatic step();
    @(negedge C7M);
    rise      = PHI1 & ~last_phi1;
    last_phi1 = PHI1;
  endtask

  task automatic rec(input int k);
    phi_pat[k]  = PHI1;
    nwe_pat[k]  = nWE;
    dev_pat[k]  = nDEVSEL;
    io_pat[k]   = nIOSEL;
    strb_pat[k] = nIOSTRB;
    oe_pat[k]   = D_oe;
    done_pat[k] = done;
    bv_pat[k]   = beat_valid;
    a_last      = A;
    dout_last   = D_out;
  endtask

  // Record one bus cycle starting at its P=0 sample; ends on the next cycle's P=0 sample.
  task automatic capture(output int n);
    {phi_pat, nwe_pat, dev_pat, io_pat, strb_pat, oe_pat, done_pat, bv_pat} = '0;
    a_p0 = A;
    rec(0);
    n = 0;
    for (int k = 1; k < 10; k++) begin
      step();
      req = 1'b0;
      if (rise) begin
        n = k;
        break;
      end
      rec(k);
    end
    if (n == 0) chk("cycle_bound", 32'(n), 32'd8);
  endtask

  task automatic sync_p0();
    for (int k = 0; k < 20 && !rise; k++) step();
    if (!rise) chk("sync_bound", 32'(rise), 32'd1);
  endtask

  task automatic rst_check();
    chk("rst_bus", 32'({A, nWE, D_oe, D_out, PHI1}), 32'({16'h0000, 1'b1, 1'b0, 8'h00, 1'b1}));
    chk("rst_sel", 32'({nDEVSEL, nIOSEL, nIOSTRB}), 32'd7);
    chk("rst_status", 32'({busy, beat_valid, done, beat_data}), 32'd0);
  endtask

  // which: 0 = no select, 1 = DEVSEL, 2 = IOSEL, 3 = IOSTRB expected during PHI0.
  task automatic txn(input logic [15:0] addr, input logic we, input logic [7:0] len,
                     input logic [7:0] wd, input logic [7:0] din0, input int which);
    int n;
    int beats;
    logic [9:0] msk;
    beats = (len == 8'd0) ? 1 : int'(len);
    sync_p0();
    req = 1'b1; req_addr = addr; req_we = we; req_len = len; wr_data = wd;
    capture(n);
    chk("arm_done_width", 32'(done_pat >> 1), 32'd0);
    chk("arm_busy", 32'(busy), 32'd1);
    for (int i = 0; i < beats; i++) begin
      D_in = din0 + 8'(i);
      capture(n);
      msk = (10'd1 << n) - 10'd1;
      chk("beat_a_p0", 32'(a_p0), 32'(addr));
      chk("beat_a_last", 32'(a_last), 32'(addr));
      chk("beat_phi1", 32'(phi_pat), 32'h00F);
      chk("beat_nwe", 32'(nwe_pat), we ? 32'd0 : 32'(msk));
      chk("beat_ndevsel", 32'(dev_pat), (which == 1) ? 32'h00F : 32'(msk));
      chk("beat_niosel", 32'(io_pat), (which == 2) ? 32'h00F : 32'(msk));
      chk("beat_niostrb", 32'(strb_pat), (which == 3) ? 32'h00F : 32'(msk));
      chk("beat_doe", 32'(oe_pat), we ? 32'(msk & ~10'h00F) : 32'd0);
      chk("beat_no_done", 32'(done_pat), 32'd0);
      chk("beat_bv_width", 32'(bv_pat >> 1), 32'd0);
      if (we) chk("beat_dout", 32'(dout_last), 32'(wd));
      chk("next_bv", 32'(beat_valid), 32'd1);
      chk("next_done", 32'(done), (i == beats - 1) ? 32'd1 : 32'd0);
      chk("next_busy", 32'(busy), (i == beats - 1) ? 32'd0 : 32'd1);
      if (!we) chk("next_beat_data", 32'(beat_data), 32'(din0 + 8'(i)));
    end
  endtask

  initial begin
    int n, n7, n8, bad, quiet;
    logic [9:0] msk;
    nRES = 1'b0; req = 1'b0; req_addr = 16'h0000; req_we = 1'b0; req_len = 8'd0;
    wr_data = 8'h00; D_in = 8'h00; last_phi1 = 1'b1; rise = 1'b0;
    repeat (3) @(negedge C7M);
    rst_check();
    nRES = 1'b1;

    // Idle bus: 64 short cycles and one long one, no selects, no driver.
    sync_p0();
    n7 = 0; n8 = 0; bad = 0;
    for (int c = 0; c < 65; c++) begin
      capture(n);
      msk = (10'd1 << n) - 10'd1;
      if (n == 7) n7++;
      else if (n == 8) n8++;
      if (phi_pat != 10'h00F) bad++;
      if (dev_pat != msk || io_pat != msk || strb_pat != msk || oe_pat != 10'd0) bad++;
    end
    chk("idle_short_cycles", 32'(n7), 32'd64);
    chk("idle_long_cycles", 32'(n8), 32'd1);
    chk("idle_bad_cycles", 32'(bad), 32'd0);

    txn(16'hC0D2, 1'b1, 8'd1, 8'h12, 8'h00, 1);
    txn(16'hC500, 1'b0, 8'd1, 8'h00, 8'hA9, 2);
    txn(16'hC0D3, 1'b0, 8'd4, 8'h00, 8'h00, 1);
    txn(16'hCFFF, 1'b0, 8'd1, 8'h00, 8'h77, 3);
    txn(16'hC300, 1'b0, 8'd1, 8'h00, 8'h42, 0);
    txn(16'hC0D2, 1'b0, 8'd0, 8'h00, 8'h5C, 1);

    // Reset in the middle of beat 2 of a 3-beat write.
    sync_p0();
    req = 1'b1; req_addr = 16'hC0D2; req_we = 1'b1; req_len = 8'd3; wr_data = 8'h33;
    capture(n);
    capture(n);
    chk("abort_beat1_valid", 32'(beat_valid), 32'd1);
    step();
    step();
    nRES = 1'b0;
    #1;
    rst_check();
    quiet = 0;
    repeat (4) begin
      step();
      if (done || busy || beat_valid) quiet++;
    end
    chk("abort_quiet", 32'(quiet), 32'd0);
    nRES = 1'b1;
    rise = 1'b0;
    last_phi1 = PHI1;
    txn(16'hC0D2, 1'b1, 8'd1, 8'h5A, 8'h00, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
